id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/mips_pkg.sv | 64 ++++++
 rtl/id_ex_reg_if.sv | 42 ++++
 rtl/fwd_unit.sv | 32 +++
 rtl/id_ex_reg.sv | 84 ++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_pkg : ALU codes, reg_dst encodings and ID/EX register layout        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package mips_pkg;

  localparam logic [4:0] c_ALU_AND = 5'b00000;
  localparam logic [4:0] c_ALU_OR  = 5'b00001;
  localparam logic [4:0] c_ALU_ADD = 5'b00010;
  localparam logic [4:0] c_ALU_SUB = 5'b00110;
  localparam logic [4:0] c_ALU_SLT = 5'b00111;
  localparam logic [4:0] c_ALU_NOR = 5'b01100;
  localparam logic [4:0] c_ALU_XOR = 5'b01101;
  localparam logic [4:0] c_ALU_SLL = 5'b10000;
  localparam logic [4:0] c_ALU_SRL = 5'b11000;
  localparam logic [4:0] c_ALU_SRA = 5'b11001;
  localparam logic [4:0] c_ALU_MUL = 5'b11010;

  typedef enum logic [1:0] {
    REG_DST_RT   = 2'd0,
    REG_DST_RD   = 2'd1,
    REG_DST_R31  = 2'd2,
    REG_DST_NONE = 2'd3
  } reg_dst_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [4:0]  alu_ctl;
    logic        sign;
    logic        src1_shamt;
    logic        src2_imm;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
  } idex_t;

  function automatic logic [31:0] ext_imm16(input logic [15:0] imm, input logic sign_ext);
    return {{16{sign_ext & imm[15]}}, imm};
  endfunction

  function automatic logic [4:0] dst_sel(input logic [1:0] sel, input logic [4:0] rt,
                                         input logic [4:0] rd);
    logic [4:0] r;
    case (reg_dst_e'(sel))
      REG_DST_RT:  r = rt;
      REG_DST_RD:  r = rd;
      REG_DST_R31: r = 5'd31;
      default:     r = 5'd0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_reg_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_reg_if : ID-side inputs, forwarding sources and EX-side outputs    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface id_ex_reg_if;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc_plus4, id_rs_data, id_rt_data;
  logic [15:0] id_imm16;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd, id_alu_ctl;
  logic        id_sign, id_ext_op, id_src1_shamt, id_src2_imm;
  logic [1:0]  id_reg_dst;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] ex_in1, ex_in2, ex_store_data, ex_pc_plus4;
  logic [4:0]  ex_alu_ctl, ex_dst;
  logic        ex_sign, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        load_use;

  modport master (
    output stall, flush, id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm16,
           id_shamt, id_rs, id_rt, id_rd, id_alu_ctl, id_sign, id_ext_op,
           id_src1_shamt, id_src2_imm, id_reg_dst, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, exmem_reg_write, memwb_reg_write,
           exmem_rd, memwb_rd, exmem_result, memwb_result,
    input  ex_in1, ex_in2, ex_store_data, ex_pc_plus4, ex_alu_ctl, ex_dst, ex_sign,
           ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use
  );

  modport slave (
    input  stall, flush, id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm16,
           id_shamt, id_rs, id_rt, id_rd, id_alu_ctl, id_sign, id_ext_op,
           id_src1_shamt, id_src2_imm, id_reg_dst, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, exmem_reg_write, memwb_reg_write,
           exmem_rd, memwb_rd, exmem_result, memwb_result,
    output ex_in1, ex_in2, ex_store_data, ex_pc_plus4, ex_alu_ctl, ex_dst, ex_sign,
           ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use
  );
endinterface
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fwd_unit : selects EX/MEM, then MEM/WB, then register-file operand data  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fwd_unit #(
  parameter int FWD_EN = 1
) (
  input  logic [4:0]  idx_i,
  input  logic [31:0] reg_data_i,
  input  logic        exmem_reg_write_i,
  input  logic [4:0]  exmem_rd_i,
  input  logic [31:0] exmem_result_i,
  input  logic        memwb_reg_write_i,
  input  logic [4:0]  memwb_rd_i,
  input  logic [31:0] memwb_result_i,
  output logic [31:0] data_o
);
  logic w_exmem_hit, w_memwb_hit;

  // r0 is hardwired to zero, so a pending write to it must never be forwarded.
  always_comb begin
    w_exmem_hit = (FWD_EN != 0) && exmem_reg_write_i && (exmem_rd_i != 5'd0) &&
                  (exmem_rd_i == idx_i);
    w_memwb_hit = (FWD_EN != 0) && memwb_reg_write_i && (memwb_rd_i != 5'd0) &&
                  (memwb_rd_i == idx_i);
    if (w_exmem_hit)      data_o = exmem_result_i;
    else if (w_memwb_hit) data_o = memwb_result_i;
    else                  data_o = reg_data_i;
  end
endmodule
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_reg : ID/EX pipeline register with operand forwarding, load-use    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module id_ex_reg
  import mips_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  id_ex_reg_if.slave idex
);
  idex_t       pipe_q, pipe_d, w_load;
  logic [31:0] w_rs_fwd, w_rt_fwd;

  always_comb begin
    w_load.valid      = idex.id_valid;
    w_load.reg_write  = idex.id_reg_write;
    w_load.mem_read   = idex.id_mem_read;
    w_load.mem_write  = idex.id_mem_write;
    w_load.mem_to_reg = idex.id_mem_to_reg;
    w_load.alu_ctl    = idex.id_alu_ctl;
    w_load.sign       = idex.id_sign;
    w_load.src1_shamt = idex.id_src1_shamt;
    w_load.src2_imm   = idex.id_src2_imm;
    w_load.pc_plus4   = idex.id_pc_plus4;
    w_load.rs_data    = idex.id_rs_data;
    w_load.rt_data    = idex.id_rt_data;
    w_load.imm_ext    = ext_imm16(idex.id_imm16, idex.id_ext_op);
    w_load.shamt      = idex.id_shamt;
    w_load.rs         = idex.id_rs;
    w_load.rt         = idex.id_rt;
    w_load.dst        = dst_sel(idex.id_reg_dst, idex.id_rt, idex.id_rd);

    // Flush wins over stall so a load-use bubble is inserted even while held.
    pipe_d = pipe_q;
    if (idex.flush) begin
      pipe_d         = '0;
      pipe_d.alu_ctl = c_ALU_AND;
    end else if (!idex.stall) begin
      pipe_d = w_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  fwd_unit #(.FWD_EN(FWD_EN)) u_fwd_rs (
    .idx_i(pipe_q.rs), .reg_data_i(pipe_q.rs_data),
    .exmem_reg_write_i(idex.exmem_reg_write), .exmem_rd_i(idex.exmem_rd),
    .exmem_result_i(idex.exmem_result),
    .memwb_reg_write_i(idex.memwb_reg_write), .memwb_rd_i(idex.memwb_rd),
    .memwb_result_i(idex.memwb_result), .data_o(w_rs_fwd)
  );

  fwd_unit #(.FWD_EN(FWD_EN)) u_fwd_rt (
    .idx_i(pipe_q.rt), .reg_data_i(pipe_q.rt_data),
    .exmem_reg_write_i(idex.exmem_reg_write), .exmem_rd_i(idex.exmem_rd),
    .exmem_result_i(idex.exmem_result),
    .memwb_reg_write_i(idex.memwb_reg_write), .memwb_rd_i(idex.memwb_rd),
    .memwb_result_i(idex.memwb_result), .data_o(w_rt_fwd)
  );

  assign idex.ex_in1        = pipe_q.src1_shamt ? {27'b0, pipe_q.shamt} : w_rs_fwd;
  assign idex.ex_in2        = pipe_q.src2_imm ? pipe_q.imm_ext : w_rt_fwd;
  assign idex.ex_store_data = w_rt_fwd;
  assign idex.ex_alu_ctl    = pipe_q.alu_ctl;
  assign idex.ex_sign       = pipe_q.sign;
  assign idex.ex_dst        = pipe_q.dst;
  assign idex.ex_pc_plus4   = pipe_q.pc_plus4;
  assign idex.ex_valid      = pipe_q.valid;
  assign idex.ex_reg_write  = pipe_q.reg_write;
  assign idex.ex_mem_read   = pipe_q.mem_read;
  assign idex.ex_mem_write  = pipe_q.mem_write;
  assign idex.ex_mem_to_reg = pipe_q.mem_to_reg;

  assign idex.load_use = pipe_q.valid & pipe_q.mem_read & (pipe_q.dst != 5'd0) &
                         ((pipe_q.dst == idex.id_rs) | (pipe_q.dst == idex.id_rt));
endmodule
`default_nettype wire
